// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte-to-serial transmitter with a 4-BC comma sync preamble
module paralelo_serial_tx #(
  parameter logic [7:0] COMMA = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       active,
  output logic       ready
);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] byte_r;
  logic [1:0] bc_cnt;
  logic       load;
  logic [7:0] next_byte;

  assign load = (cnt == 3'd7);

  // Idle fill and preamble both send the comma byte; only ACTIVE accepts user data.
  always_comb begin
    next_byte = COMMA;
    if (state == ACTIVE && valid_in) begin
      next_byte = data_in;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= 1'b0;
      cnt      <= 3'd0;
      byte_r   <= COMMA;
      bc_cnt   <= 2'd0;
      state    <= SYNC;
    end else begin
      data_out <= byte_r[3'd7 - cnt];
      cnt      <= cnt + 3'd1;
      if (load) begin
        byte_r <= next_byte;
        // Reset-loaded comma plus three preamble loads gives exactly four commas.
        if (state == SYNC) begin
          bc_cnt <= bc_cnt + 2'd1;
          if (bc_cnt == 2'd2) begin
            state <= ACTIVE;
          end
        end
      end
    end
  end

  assign active = (state == ACTIVE);
  assign ready  = (state == ACTIVE) && load;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - scoreboard bench for paralelo_serial_tx
module tb_paralelo_serial_tx;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       active;
  logic       ready;

  paralelo_serial_tx #(.COMMA(COMMA)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .data_in (data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .active  (active),
    .ready   (ready)
  );

  always #5 clk_32f = ~clk_32f;

  int         n_checks = 0;
  int         n_fail = 0;
  int         edge_n = 0;
  bit         exp_bits[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_sh = 8'h00;
  int         comma_run = 0;
  bit         rx_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic do_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    #1;
    check("rst data_out", data_out, 0);
    check("rst active", active, 0);
    check("rst ready", ready, 0);
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    edge_n = 0;
    exp_bits.delete();
    exp_bytes.delete();
    repeat (4) push_byte_bits(COMMA);
    rx_sh = 8'h00;
    comma_run = 0;
    rx_active = 1'b0;
  endtask

  // One rising edge: model the load, then pop and compare the serial bit.
  task automatic step();
    bit is_load;
    bit was_active;
    bit b;
    is_load    = (edge_n % 8 == 7);
    was_active = (edge_n >= 24);
    @(posedge clk_32f);
    #1;
    edge_n++;
    if (is_load && was_active) begin
      push_byte_bits(valid_in ? data_in : COMMA);
      if (valid_in) exp_bytes.push_back(data_in);
    end
    if (exp_bits.size() == 0) begin
      check($sformatf("bit underflow e%0d", edge_n), 1, 0);
    end else begin
      b = exp_bits.pop_front();
      check($sformatf("bit e%0d", edge_n), data_out, b);
    end
    check($sformatf("active e%0d", edge_n), active, edge_n >= 24);
    check($sformatf("ready e%0d", edge_n), ready, (edge_n >= 24) && (edge_n % 8 == 7));
    rx_sh = {rx_sh[6:0], data_out};
    if (edge_n % 8 == 0) begin
      if (rx_sh == COMMA) begin
        comma_run++;
        if (comma_run >= 4) rx_active = 1'b1;
      end else if (!rx_active) begin
        check($sformatf("rx early e%0d", edge_n), rx_sh, COMMA);
      end else if (exp_bytes.size() == 0) begin
        check($sformatf("rx unexpected e%0d", edge_n), rx_sh, COMMA);
      end else begin
        check($sformatf("rx byte e%0d", edge_n), rx_sh, exp_bytes.pop_front());
      end
    end
  endtask

  // Non-load edges get random inputs; the DUT must ignore them.
  task automatic run_to_load();
    while (edge_n % 8 != 7) begin
      valid_in = 1'($urandom);
      data_in  = 8'($urandom);
      step();
    end
  endtask

  task automatic load(input bit v, input logic [7:0] d);
    run_to_load();
    valid_in = v;
    data_in  = d;
    step();
  endtask

  initial begin
    #2;
    do_reset();

    load(1'b1, 8'hF2);
    load(1'b1, 8'h15);
    load(1'b1, 8'hDD);
    load(1'b0, 8'h00);
    load(1'b0, 8'h00);

    load(1'b1, 8'h45);
    valid_in = 1'b0;
    repeat (3) step();
    data_in = 8'hAA;
    step();
    load(1'b1, 8'hAA);
    load(1'b1, 8'h13);
    load(1'b0, 8'h00);
    load(1'b0, 8'h00);
    run_to_load();
    check("rx active", rx_active, 1);
    check("rx drained", exp_bytes.size(), 0);

    load(1'b1, 8'h5A);
    load(1'b1, 8'hFF);
    valid_in = 1'b0;
    repeat (3) step();
    #2;
    do_reset();

    load(1'b0, 8'h00);
    load(1'b1, 8'h3C);
    load(1'b0, 8'h00);
    load(1'b0, 8'h00);
    check("rx active post", rx_active, 1);
    check("rx drained post", exp_bytes.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
